// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load response buffer:
// load-op encodings, per-entry state and the address-offset width helper.
package mem_pkg;

    localparam int LOP_W   = 7;
    localparam int LOP_LB  = 0;
    localparam int LOP_LH  = 1;
    localparam int LOP_LW  = 2;
    localparam int LOP_LBU = 3;
    localparam int LOP_LHU = 4;
    localparam int LOP_LWU = 5;
    localparam int LOP_LD  = 6;

    localparam logic [LOP_W-1:0] OP_LB  = LOP_W'(1) << LOP_LB;
    localparam logic [LOP_W-1:0] OP_LH  = LOP_W'(1) << LOP_LH;
    localparam logic [LOP_W-1:0] OP_LW  = LOP_W'(1) << LOP_LW;
    localparam logic [LOP_W-1:0] OP_LBU = LOP_W'(1) << LOP_LBU;
    localparam logic [LOP_W-1:0] OP_LHU = LOP_W'(1) << LOP_LHU;
    localparam logic [LOP_W-1:0] OP_LWU = LOP_W'(1) << LOP_LWU;
    localparam logic [LOP_W-1:0] OP_LD  = LOP_W'(1) << LOP_LD;

    typedef enum logic [1:0] {
        ENT_FREE = 2'd0,
        ENT_PEND = 2'd1,
        ENT_DONE = 2'd2,
        ENT_CANC = 2'd3
    } ent_state_e;

    function automatic int addr_lo_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load aligner: picks the addressed byte/half/word out of the
// read data and sign- or zero-extends it to DATA_W bits.
module load_extract
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [LOP_W-1:0]             op_i,
    input  logic [addr_lo_w(DATA_W)-1:0] addr_lo_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic [DATA_W-1:0]            data_o
);

    localparam int AW = addr_lo_w(DATA_W);

    logic [DATA_W-1:0] byteSh;
    logic [DATA_W-1:0] halfSh;
    logic [DATA_W-1:0] wordSh;

    // On a 32-bit bus the word is always the whole bus, so lwu degenerates to lw.
    always_comb begin
        byteSh = data_i >> {addr_lo_i, 3'b000};
        halfSh = data_i >> {addr_lo_i[AW-1:1], 4'b0000};
        wordSh = data_i;
        if (DATA_W == 64) begin
            wordSh = data_i >> {addr_lo_i[AW-1], 5'b00000};
        end
        data_o = '0;
        case (op_i)
            OP_LB:   data_o = DATA_W'(signed'(byteSh[7:0]));
            OP_LH:   data_o = DATA_W'(signed'(halfSh[15:0]));
            OP_LW:   data_o = DATA_W'(signed'(wordSh[31:0]));
            OP_LBU:  data_o = DATA_W'(byteSh[7:0]);
            OP_LHU:  data_o = DATA_W'(halfSh[15:0]);
            OP_LWU:  data_o = (DATA_W == 64) ? DATA_W'(wordSh[31:0])
                                             : DATA_W'(signed'(wordSh[31:0]));
            OP_LD:   data_o = data_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_load_resp_buf.sv
// In-order load response buffer between the data SRAM and writeback.
// Optional same-cycle response bypass is enabled with `define MEM_RSP_BYPASS_EN.
module mem_load_resp_buf
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int META_W = 38
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_fire,
    input  logic [LOP_W-1:0]             req_load_op,
    input  logic [addr_lo_w(DATA_W)-1:0] req_addr_lo,
    input  logic [META_W-1:0]            req_meta,
    output logic                         req_allowin,
    input  logic                         flush,
    input  logic                         rsp_valid,
    input  logic [DATA_W-1:0]            rsp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [META_W-1:0]            out_meta,
    output logic                         busy
);

    localparam int AW = addr_lo_w(DATA_W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ent_state_e        state_q [DEPTH];
    ent_state_e        state_d [DEPTH];
    logic [LOP_W-1:0]  op_q    [DEPTH];
    logic [AW-1:0]     addr_q  [DEPTH];
    logic [META_W-1:0] meta_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d;

    logic              alloc, rspHit, rspCanc, pop;
    logic [DATA_W-1:0] extData;

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .op_i      (op_q[rptr_q]),
        .addr_lo_i (addr_q[rptr_q]),
        .data_i    (rsp_data),
        .data_o    (extData)
    );

    assign req_allowin = (count_q < CW'(DEPTH));
    assign busy        = (outst_q != '0);
    assign alloc       = req_fire && req_allowin;
    assign rspHit      = rsp_valid && (outst_q != '0);
    assign rspCanc     = rspHit && (state_q[rptr_q] == ENT_CANC);
    assign pop         = out_valid && out_ready;

    always_comb begin
        out_valid = (state_q[head_q] == ENT_DONE);
        out_data  = out_valid ? data_q[head_q] : '0;
        out_meta  = out_valid ? meta_q[head_q] : '0;
`ifdef MEM_RSP_BYPASS_EN
        if (rspHit && !flush && (state_q[head_q] == ENT_PEND) && (rptr_q == head_q)) begin
            out_valid = 1'b1;
            out_data  = extData;
            out_meta  = meta_q[head_q];
        end
`endif
    end

    // Entries before the response pointer are DONE and the rest are PENDING or
    // CANCELLED, so a flush simply frees everything up to the response pointer.
    always_comb begin
        state_d = state_q;
        if (rspHit) begin
            state_d[rptr_q] = ((state_q[rptr_q] == ENT_PEND) && !flush) ? ENT_DONE : ENT_FREE;
        end
        if (pop) begin
            state_d[head_q] = ENT_FREE;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (state_d[i] == ENT_PEND) begin
                    state_d[i] = ENT_CANC;
                end else if (state_d[i] == ENT_DONE) begin
                    state_d[i] = ENT_FREE;
                end
            end
        end
        if (alloc) begin
            state_d[tail_q] = flush ? ENT_CANC : ENT_PEND;
        end

        tail_d  = tail_q + PW'(alloc);
        rptr_d  = rptr_q + PW'(rspHit);
        outst_d = outst_q + CW'(alloc) - CW'(rspHit);
        if (flush) begin
            head_d  = rptr_d;
            count_d = outst_d;
        end else begin
            head_d  = head_q + PW'(pop) + PW'(rspCanc);
            count_d = count_q + CW'(alloc) - CW'(pop) - CW'(rspCanc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ENT_FREE;
            end
            head_q  <= '0;
            tail_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            outst_q <= outst_d;
        end
    end

    // Payload storage needs no reset: it is only observed through a DONE entry.
    always_ff @(posedge clk) begin
        if (alloc) begin
            op_q[tail_q]   <= req_load_op;
            addr_q[tail_q] <= req_addr_lo;
            meta_q[tail_q] <= req_meta;
        end
        if (rspHit) begin
            data_q[rptr_q] <= extData;
        end
    end

    a_req_when_full: assert property (@(posedge clk) disable iff (reset)
        req_fire |-> req_allowin);
    a_rsp_unexpected: assert property (@(posedge clk) disable iff (reset)
        rsp_valid |-> (outst_q != '0));
    a_ld_on_32bit: assert property (@(posedge clk) disable iff (reset)
        (req_fire && (DATA_W == 32)) |-> (req_load_op != OP_LD));

endmodule

// File: tb/tb_mem_load_resp_buf.sv
// Directed scoreboard bench for mem_load_resp_buf: a 32-bit instance for the
// buffering/flush behaviour and a 64-bit instance for extraction.
module tb_mem_load_resp_buf;

`ifdef MEM_RSP_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    localparam logic [6:0] LB  = 7'b0000001;
    localparam logic [6:0] LH  = 7'b0000010;
    localparam logic [6:0] LW  = 7'b0000100;
    localparam logic [6:0] LBU = 7'b0001000;
    localparam logic [6:0] LHU = 7'b0010000;
    localparam logic [6:0] LWU = 7'b0100000;
    localparam logic [6:0] LD  = 7'b1000000;

    typedef struct packed {
        logic [63:0] data;
        logic [37:0] meta;
    } exp_t;

    logic clk, reset;

    logic        fire, flush, rspV, ready;
    logic [6:0]  op;
    logic [1:0]  addr;
    logic [37:0] meta;
    logic [31:0] rdata;
    logic        allowin, oValid, busy;
    logic [31:0] oData;
    logic [37:0] oMeta;

    logic        fire64, flush64, rspV64, ready64;
    logic [6:0]  op64;
    logic [2:0]  addr64;
    logic [37:0] meta64;
    logic [63:0] rdata64;
    logic        allowin64, oValid64, busy64;
    logic [63:0] oData64;
    logic [37:0] oMeta64;

    exp_t sb[$];
    exp_t sb64[$];
    int   total = 0;
    int   bad   = 0;

    mem_load_resp_buf #(.DEPTH(4), .DATA_W(32), .META_W(38)) u_dut32 (
        .clk(clk), .reset(reset), .req_fire(fire), .req_load_op(op),
        .req_addr_lo(addr), .req_meta(meta), .req_allowin(allowin),
        .flush(flush), .rsp_valid(rspV), .rsp_data(rdata),
        .out_valid(oValid), .out_ready(ready), .out_data(oData),
        .out_meta(oMeta), .busy(busy)
    );

    mem_load_resp_buf #(.DEPTH(4), .DATA_W(64), .META_W(38)) u_dut64 (
        .clk(clk), .reset(reset), .req_fire(fire64), .req_load_op(op64),
        .req_addr_lo(addr64), .req_meta(meta64), .req_allowin(allowin64),
        .flush(flush64), .rsp_valid(rspV64), .rsp_data(rdata64),
        .out_valid(oValid64), .out_ready(ready64), .out_data(oData64),
        .out_meta(oMeta64), .busy(busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic f, input logic [6:0] o, input logic [1:0] a,
                                 input logic [37:0] m, input logic rv, input logic [31:0] rd,
                                 input logic fl);
        fire  = f;
        op    = o;
        addr  = a;
        meta  = m;
        rspV  = rv;
        rdata = rd;
        flush = fl;
        tick();
        fire  = 1'b0;
        rspV  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic pushExp(input logic [63:0] d, input logic [37:0] m);
        exp_t e;
        e.data = d;
        e.meta = m;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".data"}, 64'(oData), e.data);
        check({tag, ".meta"}, 64'(oMeta), 64'(e.meta));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        ready = 1'b1;
        while (sb.size() > 0 && n < budget) begin
            if (oValid) begin
                checkOutput(tag);
            end
            tick();
            n++;
        end
        ready = 1'b0;
        check({tag, ".drained"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic run64(input string tag, input logic [6:0] o, input logic [2:0] a,
                         input logic [63:0] rd, input logic [63:0] expData);
        exp_t e;
        fire64 = 1'b1;
        op64   = o;
        addr64 = a;
        meta64 = 38'h2A;
        tick();
        fire64  = 1'b0;
        rspV64  = 1'b1;
        rdata64 = rd;
        e.data  = expData;
        e.meta  = 38'h2A;
        sb64.push_back(e);
        tick();
        rspV64 = 1'b0;
        check({tag, ".valid"}, 64'(oValid64), 64'd1);
        e = sb64.pop_front();
        check({tag, ".data"}, oData64, e.data);
        ready64 = 1'b1;
        tick();
        ready64 = 1'b0;
        check({tag, ".popped"}, 64'(oValid64), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        fire = 0; flush = 0; rspV = 0; ready = 0; op = '0; addr = '0; meta = '0; rdata = '0;
        fire64 = 0; flush64 = 0; rspV64 = 0; ready64 = 0; op64 = '0; addr64 = '0;
        meta64 = '0; rdata64 = '0;
        #2;
        check("rst.valid", 64'(oValid), 64'd0);
        check("rst.data", 64'(oData), 64'd0);
        check("rst.meta", 64'(oMeta), 64'd0);
        check("rst.allowin", 64'(allowin), 64'd1);
        check("rst.busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // lb at offset 3 sign-extends 0x80; registered path shows it one cycle later
        applyStimulus(1, LB, 2'd3, 38'h1, 0, 32'h0, 0);
        check("t1.busy", 64'(busy), 64'd1);
        rspV  = 1'b1;
        rdata = 32'h80FF_1234;
        pushExp(64'(32'hFFFF_FF80), 38'h1);
        #1;
        check("t1.lat0", 64'(oValid), 64'(BYP));
        tick();
        rspV = 1'b0;
        check("t1.valid", 64'(oValid), 64'd1);
        drain("t1", 4);
        check("t1.idle", 64'(oValid), 64'd0);
        check("t1.busyEnd", 64'(busy), 64'd0);

        // fill all four entries, answer them with writeback stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            check("t2.allowin", 64'(allowin), 64'd1);
            applyStimulus(1, LW, 2'd0, 38'h10 + 38'(i), 0, 32'h0, 0);
        end
        check("t2.full", 64'(allowin), 64'd0);
        for (int i = 0; i < 4; i++) begin
            pushExp(64'(32'h11 * (i + 1)), 38'h10 + 38'(i));
            applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h11 * (i + 1), 0);
        end
        check("t2.busy", 64'(busy), 64'd0);
        check("t2.stillFull", 64'(allowin), 64'd0);
        drain("t2", 8);
        check("t2.allowinEnd", 64'(allowin), 64'd1);

        // two loads flushed before their responses return
        applyStimulus(1, LW, 2'd0, 38'h20, 0, 32'h0, 0);
        applyStimulus(1, LW, 2'd0, 38'h21, 0, 32'h0, 0);
        applyStimulus(0, LW, 2'd0, 38'h0, 0, 32'h0, 1);
        check("t3.flushValid", 64'(oValid), 64'd0);
        check("t3.flushBusy", 64'(busy), 64'd1);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h5555_5555, 0);
        check("t3.rsp1Valid", 64'(oValid), 64'd0);
        check("t3.rsp1Busy", 64'(busy), 64'd1);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h6666_6666, 0);
        check("t3.rsp2Valid", 64'(oValid), 64'd0);
        check("t3.rsp2Busy", 64'(busy), 64'd0);
        applyStimulus(1, LW, 2'd0, 38'h22, 0, 32'h0, 0);
        pushExp(64'(32'hDEAD_BEEF), 38'h22);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'hDEAD_BEEF, 0);
        drain("t3", 4);

        // flush coinciding with the only pending response leaves the buffer empty
        applyStimulus(1, LW, 2'd0, 38'h30, 0, 32'h0, 0);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h1234, 1);
        check("t4.valid", 64'(oValid), 64'd0);
        check("t4.busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, LW, 2'd0, 38'h31, 0, 32'h0, 0);
        end
        check("t4.count3", 64'(allowin), 64'd1);
        applyStimulus(1, LW, 2'd0, 38'h31, 0, 32'h0, 0);
        check("t4.count4", 64'(allowin), 64'd0);
        applyStimulus(0, LW, 2'd0, 38'h0, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h0, 0);
        end
        check("t4.busyEnd", 64'(busy), 64'd0);
        check("t4.allowinEnd", 64'(allowin), 64'd1);

        // request in the flush cycle is born cancelled
        applyStimulus(1, LW, 2'd0, 38'h40, 0, 32'h0, 1);
        check("t5.busy", 64'(busy), 64'd1);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h4040_4040, 0);
        check("t5.valid", 64'(oValid), 64'd0);
        check("t5.busyEnd", 64'(busy), 64'd0);

        // response, pop and new request all in one cycle
        applyStimulus(1, LW, 2'd0, 38'h60, 0, 32'h0, 0);
        applyStimulus(1, LW, 2'd0, 38'h61, 0, 32'h0, 0);
        pushExp(64'd1, 38'h60);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h1, 0);
        check("t6.validA", 64'(oValid), 64'd1);
        checkOutput("t6.a");
        pushExp(64'd2, 38'h61);
        ready = 1'b1;
        applyStimulus(1, LW, 2'd0, 38'h62, 1, 32'h2, 0);
        ready = 1'b0;
        check("t6.validB", 64'(oValid), 64'd1);
        pushExp(64'd3, 38'h62);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h3, 0);
        drain("t6", 6);
        check("t6.busyEnd", 64'(busy), 64'd0);

        // asynchronous reset with three entries in flight
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, LW, 2'd0, 38'h50 + 38'(i), 0, 32'h0, 0);
        end
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h77, 0);
        check("t7.validPre", 64'(oValid), 64'd1);
        reset = 1'b1;
        #1;
        check("t7.valid", 64'(oValid), 64'd0);
        check("t7.data", 64'(oData), 64'd0);
        check("t7.meta", 64'(oMeta), 64'd0);
        check("t7.allowin", 64'(allowin), 64'd1);
        check("t7.busy", 64'(busy), 64'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1, LH, 2'd2, 38'h70, 0, 32'h0, 0);
        pushExp(64'(32'hFFFF_8001), 38'h70);
        applyStimulus(0, LW, 2'd0, 38'h0, 1, 32'h8001_0000, 0);
        drain("t7", 4);

        // 64-bit extraction cases
        run64("x.lwu4", LWU, 3'd4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
        run64("x.lhu6", LHU, 3'd6, 64'h8000_0001_0000_0000, 64'h0000_0000_0000_8000);
        run64("x.ld",   LD,  3'd0, 64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000);
        run64("x.lb7",  LB,  3'd7, 64'h80FF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run64("x.lh2",  LH,  3'd2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
        run64("x.lw0",  LW,  3'd0, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_8000_0000);
        run64("x.lbu1", LBU, 3'd1, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_00F0);
        run64("x.bad",  7'b0000101, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        check("x.busyEnd", 64'(busy64), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_load_resp_buf.md
Name: mem_load_resp_buf

Overview:
- Parametrised successor to the single-outstanding memory-stage load path.
- Tracks up to DEPTH outstanding in-order data-SRAM load requests and queues per-request metadata.
- Captures responses even while writeback stalls.
- Aligns and sign/zero-extends load data for DATA_W of 32 or 64.
- Silently drains responses belonging to flushed instructions.
- Sits between the data-SRAM response channel and the writeback-side handshake.

Parameters:
- DEPTH, 4, max outstanding plus buffered requests; power of two, >=2.
- DATA_W, 32, data bus width; 32 or 64.
- META_W, 38, opaque sideband carried with each load (e.g. dest, gr_we, pc); returned unmodified.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_fire  in  1  load request accepted by SRAM this cycle (req && addr_ok)
- req_load_op  in  7  one-hot {ld, lwu, lhu, lbu, lw, lh, lb} (bit0=lb)
- req_addr_lo  in  $clog2(DATA_W/8)  low address bits of the request
- req_meta  in  META_W  sideband for this load
- req_allowin  out  1  a free entry exists; upstream must not assert req_fire when 0
- flush  in  1  pipeline flush; cancels every entry in the buffer
- rsp_valid  in  1  data_ok from data SRAM, in request order
- rsp_data  in  DATA_W  read data
- out_valid  out  1  head entry holds an extracted result
- out_ready  in  1  writeback accepts
- out_data  out  DATA_W  extracted load result
- out_meta  out  META_W  sideband of the head entry
- busy  out  1  any entry (PENDING or CANCELLED) outstanding

Behaviour:
- Circular buffer of DEPTH entries; head/tail pointers plus a count of width $clog2(DEPTH)+1. Entry state is FREE, PENDING, DONE or CANCELLED.
- Reset (async): all entries FREE, count 0, out_valid 0, out_data 0, out_meta 0, req_allowin 1, busy 0.
- Allocate on req_fire: tail entry becomes PENDING; store op, addr_lo, meta; tail++.
- req_fire while req_allowin=0 is a protocol error; an assertion fires and the request is ignored.
- On rsp_valid, the oldest PENDING-or-CANCELLED entry (the response pointer) consumes the response:
  - PENDING -> DONE, with extracted data stored.
  - CANCELLED -> FREE immediately, and head advances past it when it is at head.
- rsp_valid with no PENDING/CANCELLED entry is a protocol error; assertion, no state change.
- Output: out_valid = head entry DONE; pop on out_valid && out_ready.
- Default mode has registered output: 1-cycle latency from rsp_valid to out_valid.
- Extraction:
  - lb/lbu select byte addr_lo; lh/lhu select half addr_lo[MSB:1]; lw/lwu select word addr_lo[MSB:2].
  - Sign extension for lb/lh/lw; zero extension for lbu/lhu/lwu.
  - ld passes the full 64 bits.
  - For DATA_W=32, lwu behaves as lw; ld is illegal (assertion).
  - Non-one-hot op yields 0.
- Flush:
  - Every PENDING entry becomes CANCELLED and every DONE entry becomes FREE.
  - out_valid is 0 from the next cycle; a pop in the flush cycle is still honoured.
- Simultaneous events:
  - flush && rsp_valid: the response is consumed by its entry and discarded.
  - flush && req_fire: the new entry is allocated directly as CANCELLED.
  - rsp_valid && pop && req_fire in one cycle: all three take effect; count changes by (+1 alloc, −1 pop, −1 cancelled-free).
- Full: req_allowin = (count < DEPTH), registered-free (combinational from count only).
- Pointers wrap modulo DEPTH.
- busy = any entry PENDING or CANCELLED.

Optional Feature:
- Macro MEM_RSP_BYPASS_EN.
- Defined:
  - When the head entry is PENDING and rsp_valid arrives, out_valid/out_data present the extracted rsp_data in the same cycle.
  - If out_ready, the entry goes directly to FREE; otherwise it becomes DONE as usual.
  - No bypass while flush is asserted.
- Undefined: strictly 1-cycle registered latency.

Decomposition:
- Package mem_pkg:
  - load-op bit indices (LOP_LB..LOP_LD), LOP_W=7.
  - entry-state enum (ENT_FREE, ENT_PEND, ENT_DONE, ENT_CANC).
  - helper constant for addr_lo width.
- One natural sub-module, load_extract: purely combinational aligner/extender parameterised by DATA_W; instantiated once on rsp_data (indexed by the response-pointer entry).

Test Plan:
- DATA_W=32: req lb addr_lo=3, then rsp 0x80FF_1234 -> out_data 0xFFFF_FF80, latency 1 cycle (0 with MEM_RSP_BYPASS_EN).
- DEPTH=4: 4 back-to-back req_fire, out_ready=0 -> req_allowin=0 after the 4th. Return 4 responses 0x11,0x22,0x33,0x44 as lw -> outputs emerge in order with matching meta once out_ready=1.
- 2 outstanding loads, then flush, then 2 rsp_valid -> no out_valid, busy drops to 0 after the 2nd response. A new load issued after the flush returns 0xDEAD_BEEF correctly.
- flush and rsp_valid in the same cycle with 1 PENDING -> nothing emitted, count 0 next cycle.
- DATA_W=64: lwu addr_lo=4 on rsp 0x8000_0001_0000_0000 -> 0x0000_0000_8000_0001. lhu addr_lo=6 -> 0x8000. ld -> full word.
- Assert reset mid-operation with 3 entries -> outputs zero immediately (async), req_allowin=1.
